mem_arbiter: RTL and testbench

- Arbitrates one single-port data/instruction memory between two requesters: the instruction-fetch port (IR load) and the load/store data port (BE/DM path).
- Each requester uses a level req/ack handshake. The memory side uses a req/ready handshake with variable wait states.
- Registers the winning request, sequences the memory transaction and returns read data with a one-cycle ack.
- A watchdog terminates hung accesses with an error ack.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_timer.sv | 31 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory arbiter: FSM state encoding, grant owner
// codes, the full-word byte enable used for fetches and the watchdog width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic       OWN_I   = 1'b0;
    localparam logic       OWN_D   = 1'b1;
    localparam logic [3:0] BE_WORD = 4'hF;
    localparam int         TMR_W   = 8;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog for one memory access: cleared outside BUSY, counts wait cycles,
// flags expiry once the count reaches TIMEOUT-1. The count parks at
// TIMEOUT-1 so it can never wrap.
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [TMR_W-1:0] count;

    assign expired = (count == TMR_W'(TIMEOUT - 1));

    // Clear has priority; increment stops at the terminal value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory (instruction fetch vs
// load/store). Level req/ack on the requester side, req/ready with wait
// states on the memory side, watchdog error termination.
// Optional macro MEM_ARB_RR_EN: two-way round-robin on simultaneous requests
// (default build: fixed data-over-instruction priority).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access; pick a winner and latch its payload into m_*
// ST_BUSY | m_req held with stable payload, waiting for m_ready/timeout
// ST_RESP | one-cycle ack (and err) to the owner, then back to IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          owner,
    output logic          busy
);

    state_t state;
    logic   grant_d;
    logic   tmr_clr;
    logic   tmr_inc;
    logic   expired;

    assign busy    = (state != ST_IDLE);
    assign tmr_clr = (state != ST_BUSY);
    assign tmr_inc = (state == ST_BUSY) && !m_ready;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (expired)
    );

    // Winner selection; only consulted in IDLE when at least one req is high.
    always_comb begin
        grant_d = d_req;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            grant_d = (owner == OWN_I);
`else
            grant_d = 1'b1;
`endif
        end
    end

    // Transaction sequencer with registered memory-side and requester-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            owner   <= OWN_D;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_be    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                    if (i_req || d_req) begin
                        state <= ST_BUSY;
                        m_req <= 1'b1;
                        owner <= grant_d;
                        if (grant_d) begin
                            m_we    <= d_we;
                            m_be    <= d_be;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                        end else begin
                            m_we    <= 1'b0;
                            m_be    <= BE_WORD;
                            m_addr  <= i_addr;
                            m_wdata <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (m_ready) begin
                        state <= ST_RESP;
                        m_req <= 1'b0;
                        err   <= 1'b0;
                        if (owner == OWN_D) begin
                            d_ack <= 1'b1;
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_rdata;
                        end
                    end else if (expired) begin
                        state <= ST_RESP;
                        m_req <= 1'b0;
                        err   <= 1'b1;
                        if (owner == OWN_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= '0;
                        end
                    end
                end
                ST_RESP: begin
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes predicted responses and
// predicted memory-side requests; a memory responder and an ack monitor pop
// and compare independently.
module tb_mem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = -1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [3:0]    d_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          err;
    logic          m_req;
    logic          m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ready = 1'b0;
    logic          owner;
    logic          busy;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .err(err),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          waits;
    } mreq_t;

    resp_t       sb[$];
    mreq_t       pay[$];
    logic [31:0] ref_mem[int];
    logic [31:0] phys_mem[int];
    logic        last_grant = 1'b1;
    logic [31:0] exp_d_rdata = '0;
    int          checks = 0;
    int          errors = 0;
    int          last_ack_cyc = -100;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endfunction

    function automatic logic [31:0] init_word(input int idx);
        return (32'(idx) * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int idx;
        idx = int'(a >> 2);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return init_word(idx);
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] a);
        int idx;
        idx = int'(a >> 2);
        if (phys_mem.exists(idx)) return phys_mem[idx];
        return init_word(idx);
    endfunction

    // Reference model: one predicted access, in the order it will be granted.
    function automatic void push_txn(input bit is_d, input bit we, input logic [3:0] be,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input int waits, input bit scored);
        mreq_t m;
        resp_t r;
        m.addr  = addr;
        m.we    = is_d ? we : 1'b0;
        m.be    = is_d ? be : 4'hF;
        m.wdata = wdata;
        m.waits = waits;
        pay.push_back(m);
        if (!scored) return;
        r.is_d = is_d;
        r.err  = (waits == NEVER);
        if (r.err) begin
            r.rdata = '0;
            if (is_d) exp_d_rdata = '0;
        end else if (is_d && we) begin
            ref_mem[int'(addr >> 2)] = merge(ref_rd(addr), wdata, be);
            r.rdata = exp_d_rdata;
        end else begin
            r.rdata = ref_rd(addr);
            if (is_d) exp_d_rdata = r.rdata;
        end
        sb.push_back(r);
        last_grant = is_d;
    endfunction

    function automatic bit data_wins_tie();
`ifdef MEM_ARB_RR_EN
        return (last_grant == 1'b0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int rnd_waits();
        int r;
        r = int'($urandom_range(0, 11));
        return (r == 0) ? NEVER : (r % 5);
    endfunction

    // Memory responder: checks the request payload and its stability, then
    // answers after the predicted number of wait states (or never).
    initial begin : responder
        mreq_t       cur;
        bit          active;
        int          left;
        int          hi;
        logic [68:0] snap;
        active = 0; left = 0; hi = 0; snap = '0;
        cur.addr = '0; cur.we = 0; cur.be = '0; cur.wdata = '0; cur.waits = NEVER;
        forever begin
            @(negedge clk);
            if (!rst) begin
                active  = 0;
                m_ready = 1'b0;
                continue;
            end
            if (!active) begin
                if (!m_req) begin
                    m_ready = ($urandom_range(0, 3) == 0);
                    m_rdata = $urandom;
                    continue;
                end
                if (pay.size() == 0) begin
                    fail("unexpected_mreq", $sformatf("m_req at addr %0h with nothing predicted", m_addr));
                    cur.addr = m_addr; cur.waits = NEVER;
                end else begin
                    cur = pay.pop_front();
                    chk("m_addr", m_addr, cur.addr);
                    chk("m_we", m_we, cur.we);
                    chk("m_be", m_be, cur.be);
                    if (cur.we) chk("m_wdata", m_wdata, cur.wdata);
                end
                chk("mreq_gap_ok", (cyc - last_ack_cyc) >= 2, 1);
                active = 1;
                hi     = 1;
                left   = cur.waits;
                snap   = {m_addr, m_we, m_be, m_wdata};
            end else if (m_req) begin
                hi++;
                chk("mreq_stable", {m_addr, m_we, m_be, m_wdata} == snap, 1);
            end else begin
                chk("mreq_cycles", hi, (cur.waits == NEVER) ? TIMEOUT : cur.waits + 1);
                active  = 0;
                m_ready = 1'b0;
                continue;
            end
            if (cur.waits != NEVER && left == 0) begin
                m_ready = 1'b1;
                m_rdata = phys_rd(m_addr);
                if (m_we) phys_mem[int'(m_addr >> 2)] = merge(phys_rd(m_addr), m_wdata, m_be);
            end else begin
                m_ready = 1'b0;
                m_rdata = $urandom;
                if (cur.waits != NEVER) left--;
            end
        end
    end

    // Ack monitor: every ack pops one predicted response.
    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst && (i_ack || d_ack)) begin
                last_ack_cyc = cyc;
                if (i_ack && d_ack) fail("dual_ack", "i_ack and d_ack high together");
                if (sb.size() == 0) begin
                    fail("unexpected_ack", $sformatf("i_ack=%0b d_ack=%0b with nothing predicted", i_ack, d_ack));
                end else begin
                    r = sb.pop_front();
                    chk("ack_owner", d_ack, r.is_d);
                    chk("ack_err", err, r.err);
                    chk("ack_rdata", d_ack ? d_rdata : i_rdata, r.rdata);
                end
            end else if (err) begin
                fail("err_without_ack", "err high with no ack");
            end
        end
    end

    task automatic wait_ack(input bit is_d, input int exp_lat);
        int n;
        bit got;
        n = 0; got = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            got = is_d ? d_ack : i_ack;
        end
        if (!got) fail("ack_timeout", $sformatf("no %s ack within %0d cycles", is_d ? "d" : "i", n));
        else if (exp_lat > 0) chk("ack_latency", n, exp_lat);
    endtask

    task automatic run_i(input logic [31:0] addr, input int lat);
        @(negedge clk);
        i_req  = 1'b1;
        i_addr = addr;
        wait_ack(1'b0, lat);
        i_req  = 1'b0;
        i_addr = $urandom;
    endtask

    task automatic run_d(input bit we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat);
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = we;
        d_be    = be;
        d_addr  = addr;
        d_wdata = wdata;
        wait_ack(1'b1, lat);
        d_req   = 1'b0;
        d_wdata = $urandom;
    endtask

    task automatic do_i(input logic [31:0] addr, input int waits);
        push_txn(1'b0, 1'b0, 4'hF, addr, '0, waits, 1'b1);
        run_i(addr, (waits == NEVER) ? TIMEOUT + 1 : waits + 2);
    endtask

    task automatic do_d(input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits);
        push_txn(1'b1, we, be, addr, wdata, waits, 1'b1);
        run_d(we, be, addr, wdata, (waits == NEVER) ? TIMEOUT + 1 : waits + 2);
    endtask

    task automatic do_both(input bit we, input logic [3:0] be, input logic [31:0] daddr,
                           input logic [31:0] wdata, input int dw,
                           input logic [31:0] iaddr, input int iw);
        if (data_wins_tie()) begin
            push_txn(1'b1, we, be, daddr, wdata, dw, 1'b1);
            push_txn(1'b0, 1'b0, 4'hF, iaddr, '0, iw, 1'b1);
        end else begin
            push_txn(1'b0, 1'b0, 4'hF, iaddr, '0, iw, 1'b1);
            push_txn(1'b1, we, be, daddr, wdata, dw, 1'b1);
        end
        fork
            run_i(iaddr, 0);
            run_d(we, be, daddr, wdata, 0);
        join
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {i_ack, d_ack, err, busy, m_req, m_we, m_be}, '0);
        chk({tag, "_m_addr"}, m_addr, '0);
        chk({tag, "_m_wdata"}, m_wdata, '0);
        chk({tag, "_i_rdata"}, i_rdata, '0);
        chk({tag, "_d_rdata"}, d_rdata, '0);
        chk({tag, "_owner"}, owner, 1'b1);
    endtask

    initial begin : stimulus
        ref_mem[16]  = 32'h2408_0005;
        phys_mem[16] = 32'h2408_0005;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst = 1'b1;

        // Directed cases from the plan
        do_i(32'h0000_0040, 0);
        do_d(1'b1, 4'b0011, 32'h0000_0104, 32'hAABB_CCDD, 3);
        do_d(1'b0, 4'hF, 32'h0000_0104, '0, 1);
        do_both(1'b0, 4'hF, 32'h0000_0020, '0, 1, 32'h0000_0040, 0);
        do_both(1'b1, 4'b1100, 32'h0000_0024, 32'h1122_3344, 0, 32'h0000_0044, 2);
        do_d(1'b0, 4'hF, 32'h0000_0300, '0, NEVER);
        do_i(32'h0000_0048, NEVER);

        // Reset in the middle of a load, request held across it
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0208; d_wdata = '0;
        push_txn(1'b1, 1'b0, 4'hF, 32'h0000_0208, '0, NEVER, 1'b0);
        repeat (4) @(negedge clk);
        chk("busy_before_rst", busy, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        last_grant  = 1'b1;
        exp_d_rdata = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        push_txn(1'b1, 1'b0, 4'hF, 32'h0000_0208, '0, 2, 1'b1);
        wait_ack(1'b1, 5);
        d_req = 1'b0;

        // Back-to-back with d_req held and a new address after the ack
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0010;
        push_txn(1'b1, 1'b0, 4'hF, 32'h0000_0010, '0, 1, 1'b1);
        wait_ack(1'b1, 3);
        d_addr = 32'h0000_0014;
        push_txn(1'b1, 1'b0, 4'hF, 32'h0000_0014, '0, 0, 1'b1);
        wait_ack(1'b1, 3);
        d_req = 1'b0;

        // Randomized traffic against the reference model
        for (int k = 0; k < 40; k++) begin
            int          kind;
            logic [31:0] da;
            logic [31:0] ia;
            kind = int'($urandom_range(0, 2));
            da   = 32'($urandom_range(0, 31)) << 2;
            ia   = 32'($urandom_range(0, 31)) << 2;
            case (kind)
                0: do_i(ia, rnd_waits());
                1: do_d($urandom_range(0, 1) == 1, 4'($urandom_range(1, 15)), da, $urandom, rnd_waits());
                default: do_both($urandom_range(0, 1) == 1, 4'($urandom_range(1, 15)), da, $urandom,
                                 rnd_waits(), ia, rnd_waits());
            endcase
        end

        repeat (6) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("mreq_drained", pay.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: bench did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "global timeout");
    end

endmodule
